pixel_array_ctrl: RTL



---
 rtl/pixel_pkg.sv | 31 +++
 rtl/pixel_sample.sv | 45 ++++
 rtl/pixel_array_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel array controller.
// Holds the sequencing FSM state type, the default parameter values
// and small constant helpers used to size counters and address fields.
package pixel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ    = 3'd4
  } state_t;

  localparam int DEF_N_ROWS        = 2;
  localparam int DEF_N_COLS        = 2;
  localparam int DEF_ADC_BITS      = 8;
  localparam int DEF_ERASE_CYCLES  = 5;
  localparam int DEF_EXPOSE_CYCLES = 255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Address fields stay at least one bit wide even for a single row/column.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_sample.sv
// Per-pixel single-slope ADC capture.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clear_i      drops the captured flag (held during the erase phase)
//   convert_i    conversion window enable
//   cmp_i        comparator output of this pixel
//   ramp_i       current ramp code
//   sample_o     last captured code
module pixel_sample
  import pixel_pkg::*;
#(
  parameter int ADC_BITS = DEF_ADC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                convert_i,
  input  logic                cmp_i,
  input  logic [ADC_BITS-1:0] ramp_i,
  output logic [ADC_BITS-1:0] sample_o
);

  logic                latched_q;
  logic [ADC_BITS-1:0] sample_q;
  logic                ramp_last;

  // On the final ramp code a pixel that has not fired captures full scale,
  // which is the same value a comparator firing on that cycle would give.
  assign ramp_last = &ramp_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latched_q <= 1'b0;
      sample_q  <= '0;
    end else if (clear_i) begin
      latched_q <= 1'b0;
    end else if (convert_i && !latched_q && (cmp_i || ramp_last)) begin
      latched_q <= 1'b1;
      sample_q  <= ramp_i;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Pixel array sequencer: erase -> expose -> ramp conversion -> row-major
// readout over a valid/ready stream, optionally looping frames.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start, continuous     frame request (IDLE only) and auto-restart
//   cmp                   per-pixel comparators, index r*N_COLS+c
//   erase/expose/convert  analog phase enables (one-hot or all low)
//   ramp                  DAC code, counts during CONVERT, else 0
//   out_data/row/col      pixel sample and address, out_valid/out_ready
//   busy, frame_done      activity flag and end-of-frame pulse
module pixel_array_ctrl
  import pixel_pkg::*;
#(
  parameter int N_ROWS        = DEF_N_ROWS,
  parameter int N_COLS        = DEF_N_COLS,
  parameter int ADC_BITS      = DEF_ADC_BITS,
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [N_ROWS*N_COLS-1:0]      cmp,
  output logic                          erase,
  output logic                          expose,
  output logic                          convert,
  output logic [ADC_BITS-1:0]           ramp,
  output logic [ADC_BITS-1:0]           out_data,
  output logic [width_min1(N_ROWS)-1:0] out_row,
  output logic [width_min1(N_COLS)-1:0] out_col,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int N_PIX    = N_ROWS * N_COLS;
  localparam int RW       = width_min1(N_ROWS);
  localparam int CW       = width_min1(N_COLS);
  localparam int IW       = width_min1(N_PIX);
  localparam int RAMP_MAX = (1 << ADC_BITS) - 1;
  localparam int CNT_W    = $clog2(max3(ERASE_CYCLES, EXPOSE_CYCLES, 1 << ADC_BITS));

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              erase_q, expose_q, convert_q, out_valid_q, busy_q;
  logic [ADC_BITS-1:0] ramp_q;
  logic              xfer, last_pix;
  logic [ADC_BITS-1:0] samp [N_PIX];

  assign xfer     = out_valid_q && out_ready;
  assign last_pix = (idx_q == IW'(N_PIX - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = ERASE;
      end
      ERASE: begin
        if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          state_d = EXPOSE;
          cnt_d   = '0;
        end
      end
      EXPOSE: begin
        if (cnt_q == CNT_W'(EXPOSE_CYCLES - 1)) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        if (cnt_q == CNT_W'(RAMP_MAX)) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        cnt_d = '0;
        if (xfer) begin
          if (last_pix) begin
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
            state_d = continuous ? ERASE : IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
            if (col_q == CW'(N_COLS - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Phase enables and ramp are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      convert_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ramp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      erase_q     <= (state_d == ERASE);
      expose_q    <= (state_d == EXPOSE);
      convert_q   <= (state_d == CONVERT);
      out_valid_q <= (state_d == READ);
      busy_q      <= (state_d != IDLE);
      ramp_q      <= (state_d == CONVERT) ? cnt_d[ADC_BITS-1:0] : '0;
    end
  end

  // Flags are cleared throughout ERASE; samples keep old codes until recaptured.
  for (genvar p = 0; p < N_PIX; p++) begin : g_pix
    pixel_sample #(
      .ADC_BITS(ADC_BITS)
    ) u_pix (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (erase_q),
      .convert_i (convert_q),
      .cmp_i     (cmp[p]),
      .ramp_i    (ramp_q),
      .sample_o  (samp[p])
    );
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign ramp       = ramp_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  // Samples are static during READ, so the addressed word stays stable under stall.
  assign out_data   = samp[idx_q];
  assign frame_done = xfer && last_pix;

endmodule
